// File: rtl/boot_seq_pkg.sv
// Shared definitions for the SoC boot sequencer: state register width and state encodings.
package boot_seq_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD      = 3'd1;
  localparam logic [STATE_W-1:0] ST_HOLD      = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd4;

endpackage

// File: rtl/soc_boot_sequencer_if.sv
// Bundle of PLL, ROM-loader, user-request and CPU-reset signals around the boot sequencer.
interface soc_boot_sequencer_if;
  import boot_seq_pkg::*;

  logic   pll_locked;
  logic   loader_run;
  logic   loader_done;
  logic   user_reset_req;
  logic   reload_req;
  logic   hack_reset;
  logic   ready;
  logic   error;
  state_t state_o;

  modport master (
    input  pll_locked, loader_done, user_reset_req, reload_req,
    output loader_run, hack_reset, ready, error, state_o
  );

  modport slave (
    output pll_locked, loader_done, user_reset_req, reload_req,
    input  loader_run, hack_reset, ready, error, state_o
  );

endinterface

// File: rtl/boot_seq_timer.sv
// Saturating clear/enable up-counter; tc flags the enabled cycle whose increment reaches MAX.
module boot_seq_timer #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag is raised one cycle early so the owner can change state on the same edge the count lands on MAX.
  assign tc = en && !clr && (cnt == CW'(MAX - 1));

endmodule

// File: rtl/soc_boot_sequencer.sv
// PLL-lock / ROM-load / CPU-reset sequencer for the Hack SoC.
// Optional feature macro: BOOT_SEQ_AUTO_RETRY_EN (automatic LOAD retries from FAULT).
module soc_boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOAD_TIMEOUT_CYCLES = 1048576,
  parameter int RESET_HOLD_CYCLES   = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  soc_boot_sequencer_if.master bus
);

  if (LOCK_STABLE_CYCLES < 1 || LOAD_TIMEOUT_CYCLES < 2 ||
      RESET_HOLD_CYCLES < 1 || MAX_RETRIES < 0) begin : g_param_check
    $error("soc_boot_sequencer: illegal parameter value");
  end

  state_t state;
  state_t state_nxt;

  logic lock_clr;
  logic lock_tc;
  logic timeout_clr;
  logic timeout_tc;
  logic hold_clr;
  logic hold_tc;

  assign lock_clr    = (state != ST_WAIT_LOCK) || !bus.pll_locked;
  assign timeout_clr = (state != ST_LOAD);

`ifdef BOOT_SEQ_AUTO_RETRY_EN
  // The hold timer doubles as the retry back-off delay while in FAULT.
  assign hold_clr = !((state == ST_HOLD) || (state == ST_FAULT));
`else
  assign hold_clr = (state != ST_HOLD);
`endif

  boot_seq_timer #(.MAX(LOCK_STABLE_CYCLES)) u_lock_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (lock_clr),
    .en    (bus.pll_locked),
    .tc    (lock_tc)
  );

  boot_seq_timer #(.MAX(LOAD_TIMEOUT_CYCLES)) u_timeout_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timeout_clr),
    .en    (1'b1),
    .tc    (timeout_tc)
  );

  boot_seq_timer #(.MAX(RESET_HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr),
    .en    (1'b1),
    .tc    (hold_tc)
  );

`ifdef BOOT_SEQ_AUTO_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [RW-1:0] retry_cnt;
  logic          retry_ok;

  assign retry_ok = (retry_cnt < RW'(MAX_RETRIES));

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if ((state_nxt == ST_RUN) || (state_nxt == ST_WAIT_LOCK)) begin
      retry_cnt <= '0;
    end else if ((state == ST_FAULT) && bus.reload_req) begin
      retry_cnt <= '0;
    end else if ((state == ST_FAULT) && (state_nxt == ST_LOAD)) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end
`endif

  // Lock loss overrides every other request outside WAIT_LOCK.
  always_comb begin
    state_nxt = state;
    if ((state != ST_WAIT_LOCK) && !bus.pll_locked) begin
      state_nxt = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (lock_tc)                       state_nxt = ST_LOAD;
        ST_LOAD:      if (bus.loader_done)               state_nxt = ST_HOLD;
                      else if (timeout_tc)               state_nxt = ST_FAULT;
        ST_HOLD:      if (hold_tc)                       state_nxt = ST_RUN;
        ST_RUN:       if (bus.reload_req)                state_nxt = ST_LOAD;
`ifdef BOOT_SEQ_AUTO_RETRY_EN
        ST_FAULT:     if (bus.reload_req)                state_nxt = ST_LOAD;
                      else if (hold_tc && retry_ok)      state_nxt = ST_LOAD;
`else
        ST_FAULT:     if (bus.reload_req)                state_nxt = ST_LOAD;
`endif
        default:                                         state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_WAIT_LOCK;
      bus.loader_run <= 1'b0;
      bus.hack_reset <= 1'b1;
      bus.ready      <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.loader_run <= (state_nxt == ST_LOAD);
      bus.hack_reset <= (state_nxt == ST_RUN) ? bus.user_reset_req : 1'b1;
      bus.ready      <= (state_nxt == ST_RUN);
      bus.error      <= (state_nxt == ST_FAULT);
    end
  end

  assign bus.state_o = state;

endmodule

// File: tb/tb_soc_boot_sequencer.sv
// Directed table-driven bench for soc_boot_sequencer (LOCK=4, TIMEOUT=20, HOLD=8, RETRIES=3).
module tb_soc_boot_sequencer;

  typedef struct {
    logic       lk;
    logic       dn;
    logic       ur;
    logic       rl;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  soc_boot_sequencer_if bus();

  soc_boot_sequencer #(
    .LOCK_STABLE_CYCLES  (4),
    .LOAD_TIMEOUT_CYCLES (20),
    .RESET_HOLD_CYCLES   (8),
    .MAX_RETRIES         (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [6:0] act = {bus.state_o, bus.loader_run, bus.hack_reset, bus.ready, bus.error};

  // Packed view: {state, loader_run, hack_reset, ready, error}.
  function automatic logic [6:0] o(logic [2:0] st, logic run, logic hr, logic rdy, logic err);
    return {st, run, hr, rdy, err};
  endfunction

  task automatic check(string name, int a, int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
    end
  endtask

  task automatic drive(logic lk, logic dn, logic ur, logic rl);
    bus.pll_locked     = lk;
    bus.loader_done    = dn;
    bus.user_reset_req = ur;
    bus.reload_req     = rl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(int n, logic lk, logic dn, logic ur, logic rl, logic [6:0] e);
    vec_t v;
    v.lk = lk; v.dn = dn; v.ur = ur; v.rl = rl; v.exp = e;
    repeat (n) vecs.push_back(v);
  endtask

  int   visits;
  logic prev_run;
  int   exp_visits;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Inputs -> expected outputs after the next edge.
    add(2,  1,0,0,0, o(0,0,1,0,0));  // lock count 1,2
    add(1,  0,0,0,0, o(0,0,1,0,0));  // glitch restarts count
    add(3,  1,0,0,0, o(0,0,1,0,0));
    add(1,  1,0,0,0, o(1,1,1,0,0));  // 4th stable cycle -> LOAD
    add(9,  1,0,0,0, o(1,1,1,0,0));
    add(1,  1,1,0,0, o(2,0,1,0,0));  // done in 10th LOAD cycle
    add(1,  1,0,0,1, o(2,0,1,0,0));  // reload ignored in HOLD
    add(6,  1,0,0,0, o(2,0,1,0,0));
    add(1,  1,0,0,0, o(3,0,0,1,0));  // RUN after 8 HOLD cycles
    add(5,  1,0,1,0, o(3,0,1,1,0));  // user reset, one-cycle lag
    add(2,  1,0,0,0, o(3,0,0,1,0));
    add(1,  1,0,0,1, o(1,1,1,0,0));  // reload from RUN
    add(19, 1,0,0,0, o(1,1,1,0,0));
    add(1,  1,0,0,0, o(4,0,1,0,1));  // timeout after 20 LOAD cycles
    add(2,  1,0,0,0, o(4,0,1,0,1));
    add(1,  1,0,0,1, o(1,1,1,0,0));  // reload from FAULT
    add(19, 1,0,0,0, o(1,1,1,0,0));
    add(1,  1,1,0,0, o(2,0,1,0,0));  // done on timeout cycle wins
    add(7,  1,0,0,0, o(2,0,1,0,0));
    add(1,  1,0,0,0, o(3,0,0,1,0));
    add(1,  0,0,0,1, o(0,0,1,0,0));  // lock loss beats reload
    add(1,  1,0,0,1, o(0,0,1,0,0));  // reload ignored in WAIT_LOCK
    add(2,  1,0,0,0, o(0,0,1,0,0));
    add(1,  1,0,0,0, o(1,1,1,0,0));
    add(3,  1,0,0,0, o(1,1,1,0,0));
    add(1,  0,1,0,0, o(0,0,1,0,0));  // lock loss beats done

    repeat (3) step();
    check("reset_state", act, o(0,0,1,0,0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lk, vecs[i].dn, vecs[i].ur, vecs[i].rl);
      step();
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Reset in the middle of LOAD.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("load_entry", act, o(1,1,1,0,0));
    reset = 1'b1;
    step();
    check("reset_mid_load", act, o(0,0,1,0,0));
    reset = 1'b0;
    repeat (3) step();
    check("relock_count", act, o(0,0,1,0,0));
    step();
    check("relock_load", act, o(1,1,1,0,0));

    // Lock loss while holding the CPU in reset.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("hold_entry", act, o(2,0,1,0,0));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("hold_lock_loss", act, o(0,0,1,0,0));

    // Loader never completes: count LOAD visits over a bounded window.
`ifdef BOOT_SEQ_AUTO_RETRY_EN
    exp_visits = 4;
`else
    exp_visits = 1;
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    visits   = 0;
    prev_run = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (bus.loader_run && !prev_run) visits++;
      prev_run = bus.loader_run;
    end
    check("load_visits", visits, exp_visits);
    check("fault_parked", act, o(4,0,1,0,1));

    drive(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("fault_reload", act, o(1,1,1,0,0));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("final_hold", act, o(2,0,1,0,0));
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) step();
    check("final_hold_end", act, o(2,0,1,0,0));
    step();
    check("final_run", act, o(3,0,0,1,0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
